// File: rtl/sig_pkg.sv
// Sample format shared between the sine generator and the PWM DAC.
package sig_pkg;
    localparam int SAMPLE_W = 8;
    localparam int DIV_W    = 16;

    typedef logic [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/pwm_dac_if.sv
// Valid/ready sample stream from the upstream generator into the PWM DAC.
interface pwm_dac_if import sig_pkg::*; #(
    parameter int D_WIDTH = SAMPLE_W
);
    logic [D_WIDTH-1:0] sample_in;
    logic               sample_valid;
    logic               sample_ready;

    modport master (output sample_in, output sample_valid, input  sample_ready);
    modport slave  (input  sample_in, input  sample_valid, output sample_ready);
endinterface

// File: rtl/pwm_dac_tick_gen.sv
// Prescaler: one tick every DIV enabled cycles; the count freezes while en is low.
module tick_gen import sig_pkg::*; #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] pre_q;
    logic [DIV_W-1:0] pre_d;

    // prescaler next state and tick decode
    always_comb begin
        pre_d = pre_q;
        tick  = 1'b0;
        if (en) begin
            if (pre_q == LAST) begin
                pre_d = '0;
                tick  = 1'b1;
            end else begin
                pre_d = pre_q + DIV_W'(1'b1);
            end
        end else begin
            pre_d = pre_q;
        end
    end

    // prescaler register
    always_ff @(posedge clk) begin
        if (!rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
endmodule

// File: rtl/pwm_dac.sv
// PWM DAC: a one-deep sample buffer feeds a duty register that is reloaded only
// at PWM period boundaries; a missing sample repeats the old duty and flags underrun.
module pwm_dac import sig_pkg::*; #(
    parameter int D_WIDTH = SAMPLE_W,
    parameter int DIV     = 1
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     en,
    pwm_dac_if.slave smp,
    output logic     pwm_out,
    output logic     period_start,
    output logic     underrun
);
    localparam logic [D_WIDTH-1:0] CNT_LAST = '1;

    logic               tick_s;
    logic               boundary_s;
    logic               accept_s;
    logic [D_WIDTH-1:0] cnt_q, cnt_d;
    logic [D_WIDTH-1:0] duty_q, duty_d;
    logic [D_WIDTH-1:0] hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic               ready_q, ready_d;
    logic               pwm_q, pwm_d;
    logic               ps_q, ps_d;
    logic               underrun_q, underrun_d;

    tick_gen #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (tick_s)
    );

    // next-state logic for counter, buffer, duty and status flags
    always_comb begin
        boundary_s  = tick_s && (cnt_q == CNT_LAST);
        accept_s    = smp.sample_valid && ready_q;
        cnt_d       = cnt_q;
        duty_d      = duty_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        pwm_d       = pwm_q;
        underrun_d  = underrun_q;
        ps_d        = boundary_s;

        if (tick_s) begin
            cnt_d = cnt_q + D_WIDTH'(1'b1);
        end else begin
            cnt_d = cnt_q;
        end

        if (en) begin
            pwm_d = (cnt_q < duty_q);
        end else begin
            pwm_d = pwm_q;
        end

        // ready is low while the buffer is full, so a load and an accept never collide
        if (boundary_s && hold_full_q) begin
            duty_d      = hold_q;
            hold_full_d = 1'b0;
        end else if (accept_s) begin
            hold_d      = smp.sample_in;
            hold_full_d = 1'b1;
        end else begin
            hold_full_d = hold_full_q;
        end

        if (boundary_s && !hold_full_q) begin
            underrun_d = 1'b1;
        end else begin
            underrun_d = underrun_q;
        end

        ready_d = !hold_full_d;
    end

    // all state registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q       <= '0;
            duty_q      <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            ready_q     <= 1'b1;
            pwm_q       <= 1'b0;
            ps_q        <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            duty_q      <= duty_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            ready_q     <= ready_d;
            pwm_q       <= pwm_d;
            ps_q        <= ps_d;
            underrun_q  <= underrun_d;
        end
    end

    assign smp.sample_ready = ready_q;
    assign pwm_out          = pwm_q;
    assign period_start     = ps_q;
    assign underrun         = underrun_q;
endmodule

// File: tb/tb_pwm_dac.sv
// Bench for pwm_dac: a period-arithmetic reference model checks the DIV=1 instance
// every cycle; tables and directed sequences cover duty, stalls, reset and DIV=4.
module tb_pwm_dac;
    import sig_pkg::*;

    localparam int PER = 256;

    typedef struct {
        logic [7:0] sample;
        int         exp_high;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1, en1, pwm1, ps1, ur1;
    logic rst4, en4, pwm4, ps4, ur4;

    pwm_dac_if #(.D_WIDTH(8)) if1 ();
    pwm_dac_if #(.D_WIDTH(8)) if4 ();

    pwm_dac #(.D_WIDTH(8), .DIV(1)) dut1 (
        .clk(clk), .rst(rst1), .en(en1), .smp(if1.slave),
        .pwm_out(pwm1), .period_start(ps1), .underrun(ur1)
    );

    pwm_dac #(.D_WIDTH(8), .DIV(4)) dut4 (
        .clk(clk), .rst(rst4), .en(en4), .smp(if4.slave),
        .pwm_out(pwm4), .period_start(ps4), .underrun(ur4)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference model: position in enabled cycles since reset, FIFO of buffered samples
    int         m_pos;
    logic [7:0] m_duty;
    logic [7:0] m_q[$];
    logic       m_pwm, m_ps, m_ur;
    logic       auto_feed = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic bnd, acc;
        if (!rst1) begin
            m_pos = 0; m_duty = 8'h00; m_q.delete();
            m_pwm = 1'b0; m_ps = 1'b0; m_ur = 1'b0;
        end else begin
            acc = if1.sample_valid && (m_q.size() == 0);
            bnd = en1 && ((m_pos % PER) == PER - 1);
            if (en1) begin
                m_pwm = ((m_pos % PER) < int'(m_duty));
                m_pos++;
            end
            m_ps = bnd;
            if (bnd) begin
                if (m_q.size() > 0) m_duty = m_q.pop_front();
                else m_ur = 1'b1;
            end
            if (acc) m_q.push_back(if1.sample_in);
        end
    endtask

    // one clock: model advances on the edge, outputs compared on the falling edge
    task automatic tick1();
        logic acc1;
        acc1 = if1.sample_valid && if1.sample_ready;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("model_pwm_out", int'(pwm1), int'(m_pwm));
        chk("model_period_start", int'(ps1), int'(m_ps));
        chk("model_underrun", int'(ur1), int'(m_ur));
        chk("model_sample_ready", int'(if1.sample_ready), int'(m_q.size() == 0));
        if (auto_feed && acc1) if1.sample_in = if1.sample_in + 8'h10;
    endtask

    task automatic do_reset();
        rst1 = 1'b0; rst4 = 1'b0; en1 = 1'b0; en4 = 1'b0;
        if1.sample_valid = 1'b0; if4.sample_valid = 1'b0;
        tick1();
        rst1 = 1'b1; rst4 = 1'b1;
    endtask

    task automatic feed1(input logic [7:0] v);
        if1.sample_valid = 1'b1; if1.sample_in = v;
        tick1();
        if1.sample_valid = 1'b0;
    endtask

    task automatic wait_ps1(input int limit, output int cycles);
        cycles = 0;
        do begin
            tick1();
            cycles++;
        end while (!ps1 && cycles < limit);
        chk("wait_period_start_timeout", int'(ps1), 1);
    endtask

    // called in a period_start cycle; feeds next_v and measures one full period
    task automatic play_period(input logic [7:0] next_v, input int exp_high);
        int highs;
        highs = 0;
        if1.sample_valid = 1'b1; if1.sample_in = next_v;
        for (int j = 0; j < PER; j++) begin
            tick1();
            if1.sample_valid = 1'b0;
            highs += int'(pwm1);
            if (j < PER - 1) chk("period_no_early_strobe", int'(ps1), 0);
        end
        chk("period_high_count", highs, exp_high);
        chk("period_length_256", int'(ps1), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        int   c, n, highs;
        logic frz;

        tbl[0] = '{8'h40, 64};  tbl[1] = '{8'h00, 0};   tbl[2] = '{8'h01, 1};
        tbl[3] = '{8'h80, 128}; tbl[4] = '{8'hFF, 255}; tbl[5] = '{8'h40, 64};

        if1.sample_in = 8'h00; if4.sample_in = 8'h00;
        do_reset();
        chk("reset_pwm_out", int'(pwm1), 0);
        chk("reset_period_start", int'(ps1), 0);
        chk("reset_underrun", int'(ur1), 0);
        chk("reset_sample_ready", int'(if1.sample_ready), 1);
        chk("reset4_ready", int'(if4.sample_ready), 1);
        chk("reset4_outputs", int'({pwm4, ps4, ur4}), 0);

        // idle after reset: strobe in cycle 257, underrun set
        en1 = 1'b1;
        for (int i = 0; i < PER - 1; i++) begin
            tick1();
            chk("idle_pwm_low", int'(pwm1), 0);
            chk("idle_no_strobe", int'(ps1), 0);
        end
        tick1();
        chk("idle_strobe_cycle_257", int'(ps1), 1);
        chk("idle_underrun", int'(ur1), 1);

        // table of duty values, one fresh sample per period
        do_reset();
        en1 = 1'b1;
        feed1(tbl[0].sample);
        wait_ps1(300, c);
        chk("first_strobe_latency", c, PER - 1);
        for (int i = 0; i < 6; i++) play_period(tbl[(i + 1) % 6].sample, tbl[i].exp_high);
        chk("stream_no_underrun", int'(ur1), 0);

        // valid held high with an incrementing source: one sample per period, in order
        do_reset();
        en1 = 1'b1;
        if1.sample_in = 8'h10; if1.sample_valid = 1'b1; auto_feed = 1'b1;
        wait_ps1(300, c);
        for (int p = 0; p < 3; p++) begin
            highs = 0;
            for (int j = 0; j < PER; j++) begin
                tick1();
                highs += int'(pwm1);
                if (j == 10) chk("backpressure_ready_low", int'(if1.sample_ready), 0);
            end
            chk("continuous_high_count", highs, 16 * (p + 1));
            chk("continuous_strobe", int'(ps1), 1);
        end
        chk("continuous_no_underrun", int'(ur1), 0);
        auto_feed = 1'b0; if1.sample_valid = 1'b0;

        // en low for 10 cycles mid-period stretches the period by 10
        do_reset();
        en1 = 1'b1;
        feed1(8'h80);
        wait_ps1(300, c);
        feed1(8'h80);
        n = 1; highs = int'(pwm1);
        for (int j = 0; j < 99; j++) begin tick1(); n++; highs += int'(pwm1); end
        frz = pwm1;
        en1 = 1'b0;
        for (int j = 0; j < 10; j++) begin
            tick1(); n++; highs += int'(pwm1);
            chk("freeze_pwm_hold", int'(pwm1), int'(frz));
            chk("freeze_no_strobe", int'(ps1), 0);
        end
        en1 = 1'b1;
        while (!ps1 && n < 400) begin tick1(); n++; highs += int'(pwm1); end
        chk("freeze_period_266", n, PER + 10);
        chk("freeze_high_count", highs, 128 + 10);

        // reset pulse mid-period with a buffered sample
        do_reset();
        en1 = 1'b1;
        feed1(8'h80);
        wait_ps1(300, c);
        feed1(8'hC0);
        chk("buffer_full_ready_low", int'(if1.sample_ready), 0);
        for (int j = 0; j < 49; j++) tick1();
        rst1 = 1'b0;
        tick1();
        chk("midreset_pwm_out", int'(pwm1), 0);
        chk("midreset_period_start", int'(ps1), 0);
        chk("midreset_underrun", int'(ur1), 0);
        chk("midreset_sample_ready", int'(if1.sample_ready), 1);
        rst1 = 1'b1;
        highs = 0;
        for (int j = 0; j < PER - 1; j++) begin
            tick1(); highs += int'(pwm1);
            chk("midreset_no_partial_strobe", int'(ps1), 0);
        end
        tick1(); highs += int'(pwm1);
        chk("midreset_strobe", int'(ps1), 1);
        chk("midreset_underrun_after", int'(ur1), 1);
        for (int j = 0; j < PER; j++) begin tick1(); highs += int'(pwm1); end
        chk("midreset_buffer_discarded", highs, 0);

        // DIV=4 instance with full-scale sample
        do_reset();
        en4 = 1'b1;
        if4.sample_valid = 1'b1; if4.sample_in = 8'hFF;
        tick1();
        if4.sample_valid = 1'b0;
        n = 1;
        while (!ps4 && n < 1100) begin tick1(); n++; end
        chk("div4_first_strobe", n, 4 * PER);
        if4.sample_valid = 1'b1;
        n = 0; highs = 0;
        do begin
            tick1(); if4.sample_valid = 1'b0; n++; highs += int'(pwm4);
        end while (!ps4 && n < 1100);
        chk("div4_period_1024", n, 4 * PER);
        chk("div4_high_1020", highs, 1020);
        chk("div4_no_underrun", int'(ur4), 0);
        en4 = 1'b0;

        // randomized traffic against the model
        do_reset();
        for (int j = 0; j < 3000; j++) begin
            rst1 = ($urandom_range(0, 399) != 0);
            en1 = ($urandom_range(0, 7) != 0);
            if1.sample_valid = ($urandom_range(0, 2) == 0);
            if1.sample_in = 8'($urandom);
            tick1();
        end
        rst1 = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
